// File: rtl/apb_pkg.sv
// Shared types and bus widths for the APB initiator that drives the APB-to-I2C bridge.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 3;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_requester.sv
// APB3 initiator: converts single-beat valid/ready commands into IDLE->SETUP->ACCESS transfers
// and reports read data or a timeout on a one-cycle response strobe.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            APB_IDLE: begin
                // The bus registers double as the command latch; they hold while idle.
                if (cmd_valid_i) begin
                    state_d  = APB_SETUP;
                    pwrite_d = cmd_write_i;
                    paddr_d  = cmd_addr_i;
                    pwdata_d = cmd_wdata_i;
                    cnt_d    = '0;
                end
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (pready) begin
                    state_d     = APB_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = APB_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase

        psel_d    = (state_d != APB_IDLE);
        penable_d = (state_d == APB_ACCESS);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= APB_IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o = (state_q == APB_IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: transfers, wait states, timeout, back-to-back and reset.
module tb_apb_requester;

    logic       clk_i = 1'b0;
    logic       reset_n;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_write_i;
    logic [2:0] cmd_addr_i;
    logic [7:0] cmd_wdata_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic       rsp_err_o;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;

    int n_checks = 0;
    int n_pass   = 0;
    int rsp_count = 0;
    int saved_count;
    bit access_ok;

    apb_requester #(
        .ADDR_W        (3),
        .DATA_W        (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rsp_valid_o) rsp_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cmd(input logic wr, input logic [2:0] addr, input logic [7:0] wdata);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
    endtask

    initial begin
        reset_n     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        prdata      = '0;
        pready      = 1'b0;
        tick();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_paddr", paddr, 0);
        check("rst_ready", cmd_ready_o, 1);
        reset_n = 1'b1;
        tick();

        // 1: write, zero wait states
        set_cmd(1'b1, 3'h2, 8'hA5);
        pready = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        check("t1_setup_psel", psel, 1);
        check("t1_setup_penable", penable, 0);
        check("t1_setup_ready", cmd_ready_o, 0);
        check("t1_pwrite", pwrite, 1);
        check("t1_paddr", paddr, 3'h2);
        check("t1_pwdata", pwdata, 8'hA5);
        tick();
        check("t1_access_penable", penable, 1);
        check("t1_access_rsp", rsp_valid_o, 0);
        tick();
        check("t1_rsp_valid", rsp_valid_o, 1);
        check("t1_rsp_err", rsp_err_o, 0);
        check("t1_rsp_rdata", rsp_rdata_o, 8'h00);
        check("t1_idle_psel", psel, 0);
        check("t1_idle_paddr_hold", paddr, 3'h2);
        tick();
        check("t1_rsp_drop", rsp_valid_o, 0);

        // 2: read with three wait states
        pready = 1'b0;
        set_cmd(1'b0, 3'h5, 8'hFF);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        access_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!(psel && penable && !pwrite && paddr == 3'h5 && !rsp_valid_o)) access_ok = 1'b0;
            if (i == 3) begin
                pready = 1'b1;
                prdata = 8'h3C;
            end
            tick();
        end
        check("t2_access_stable", access_ok, 1);
        pready = 1'b0;
        prdata = 8'h00;
        check("t2_rsp_valid", rsp_valid_o, 1);
        check("t2_rsp_rdata", rsp_rdata_o, 8'h3C);
        check("t2_rsp_err", rsp_err_o, 0);
        check("t2_idle_psel", psel, 0);
        tick();
        check("t2_rdata_clear", rsp_rdata_o, 8'h00);

        // 3: timeout after 16 ACCESS cycles
        prdata = 8'hEE;
        set_cmd(1'b1, 3'h7, 8'h5A);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        access_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (!(psel && penable && !rsp_valid_o)) access_ok = 1'b0;
            tick();
        end
        check("t3_access_16", access_ok, 1);
        check("t3_psel_drop", psel, 0);
        check("t3_rsp_valid", rsp_valid_o, 1);
        check("t3_rsp_err", rsp_err_o, 1);
        check("t3_rsp_rdata", rsp_rdata_o, 8'h00);
        tick();
        check("t3_err_clear", rsp_err_o, 0);
        prdata = 8'h00;

        // 4: back-to-back with cmd_valid held high
        saved_count = rsp_count;
        pready = 1'b1;
        prdata = 8'h77;
        set_cmd(1'b1, 3'h1, 8'h11);
        tick();
        set_cmd(1'b0, 3'h4, 8'h00);
        check("t4_w_setup_ready", cmd_ready_o, 0);
        check("t4_w_pwdata", pwdata, 8'h11);
        tick();
        check("t4_w_access_ready", cmd_ready_o, 0);
        tick();
        check("t4_idle_psel", psel, 0);
        check("t4_idle_ready", cmd_ready_o, 1);
        check("t4_w_rsp", rsp_valid_o, 1);
        tick();
        cmd_valid_i = 1'b0;
        check("t4_r_setup_psel", psel, 1);
        check("t4_r_paddr", paddr, 3'h4);
        check("t4_r_pwrite", pwrite, 0);
        tick();
        tick();
        check("t4_r_rsp", rsp_valid_o, 1);
        check("t4_r_rdata", rsp_rdata_o, 8'h77);
        tick();
        check("t4_two_strobes", rsp_count - saved_count, 2);
        prdata = 8'h00;

        // 5: reset asserted during ACCESS
        pready = 1'b0;
        set_cmd(1'b1, 3'h3, 8'hC3);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        check("t5_in_access", penable, 1);
        saved_count = rsp_count;
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_psel", psel, 0);
        check("t5_async_penable", penable, 0);
        pready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        check("t5_no_rsp", rsp_count - saved_count, 0);
        set_cmd(1'b1, 3'h6, 8'h9E);
        tick();
        cmd_valid_i = 1'b0;
        check("t5_new_pwdata", pwdata, 8'h9E);
        tick();
        tick();
        check("t5_new_rsp", rsp_valid_o, 1);
        check("t5_new_err", rsp_err_o, 0);
        tick();

        // 6: pready high during SETUP is ignored
        pready = 1'b1;
        prdata = 8'hE7;
        set_cmd(1'b0, 3'h1, 8'h00);
        tick();
        cmd_valid_i = 1'b0;
        check("t6_setup_penable", penable, 0);
        check("t6_setup_rsp", rsp_valid_o, 0);
        tick();
        check("t6_access_penable", penable, 1);
        check("t6_access_rsp", rsp_valid_o, 0);
        tick();
        check("t6_rsp_valid", rsp_valid_o, 1);
        check("t6_rsp_rdata", rsp_rdata_o, 8'hE7);
        pready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
